// File: rtl/serial_link_peer_pkg.sv
// Shared types and constants for the cable-side serial link peer.
package serial_link_peer_pkg;
  typedef enum logic {IDLE, SHIFT} state_e;

  localparam int              BITS      = 8;
  localparam int              CNT_W     = $clog2(BITS);
  localparam logic [BITS-1:0] IDLE_BYTE = 8'hFF;
endpackage

// File: rtl/serial_link_peer_sync.sv
// Two-flop synchronizer with a third flop for rise/fall pulse detection.
module serial_link_peer_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic nreset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);
  logic [2:0] ff_q, ff_d;

  assign ff_d = {ff_q[1:0], d_i};

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) ff_q <= {3{RST_VAL}};
    else         ff_q <= ff_d;
  end

  assign q_o    = ff_q[1];
  assign rise_o =  ff_q[1] & ~ff_q[2];
  assign fall_o = ~ff_q[1] &  ff_q[2];
endmodule

// File: rtl/serial_link_peer.sv
// Cable-side SB/SC link partner: slave by default; clock-master mode is built
// only when SERIAL_LINK_PEER_MASTER_EN is defined.
module serial_link_peer
  import serial_link_peer_pkg::*;
#(
  parameter int HALF_PERIOD = 64
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            sck_in,
  output logic            sck_out,
  output logic            sck_oe,
  input  logic            sin,
  output logic            sout,
  input  logic            master,
  input  logic [BITS-1:0] tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [BITS-1:0] rx_data,
  output logic            rx_valid,
  output logic            busy
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BITS-1:0]  shreg_q, shreg_d, shreg_eff;
  logic [BITS-1:0]  rx_data_q, rx_data_d;
  logic             sout_q, sout_d;
  logic             low_q, low_d;
  logic             rx_valid_q, rx_valid_d;

  logic sck_rise, sck_fall, sin_s, load, last_bit;
  logic m_act, m_start, m_rise, m_fall, rise_ev, fall_ev;
  logic sck_q_unused, sin_rise_unused, sin_fall_unused;

  serial_link_peer_sync #(.RST_VAL(1'b1)) u_sync_sck (
    .clk    (clk),
    .nreset (nreset),
    .d_i    (sck_in),
    .q_o    (sck_q_unused),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  serial_link_peer_sync #(.RST_VAL(1'b1)) u_sync_sin (
    .clk    (clk),
    .nreset (nreset),
    .d_i    (sin),
    .q_o    (sin_s),
    .rise_o (sin_rise_unused),
    .fall_o (sin_fall_unused)
  );

  assign load      = tx_valid && (state_q == IDLE);
  assign shreg_eff = load ? tx_data : shreg_q;
  assign last_bit  = (bit_cnt_q == CNT_W'(BITS - 1));
  // While we own the clock, our own edges replace the synchronized cable edges.
  assign rise_ev   = m_act ? m_rise : sck_rise;
  assign fall_ev   = m_act ? m_fall : sck_fall;

`ifdef SERIAL_LINK_PEER_MASTER_EN
  localparam int HP_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [HP_W-1:0] hp_cnt_q, hp_cnt_d;
  logic            m_act_q, m_act_d;
  logic            sck_out_q, sck_out_d;
  logic            m_tick;

  assign m_start = load && master;
  assign m_tick  = m_act_q && (hp_cnt_q == HP_W'(HALF_PERIOD - 1));
  assign m_rise  = m_tick && !sck_out_q;
  assign m_fall  = m_tick &&  sck_out_q;
  assign m_act   = m_act_q;

  always_comb begin
    hp_cnt_d  = hp_cnt_q;
    m_act_d   = m_act_q;
    sck_out_d = sck_out_q;
    if (m_start) begin
      m_act_d   = 1'b1;
      sck_out_d = 1'b0;
      hp_cnt_d  = '0;
    end else if (m_act_q) begin
      if (m_tick) begin
        hp_cnt_d  = '0;
        sck_out_d = ~sck_out_q;
        if (m_rise && last_bit) m_act_d = 1'b0;
      end else begin
        hp_cnt_d = hp_cnt_q + HP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hp_cnt_q  <= '0;
      m_act_q   <= 1'b0;
      sck_out_q <= 1'b1;
    end else begin
      hp_cnt_q  <= hp_cnt_d;
      m_act_q   <= m_act_d;
      sck_out_q <= sck_out_d;
    end
  end

  assign sck_out = sck_out_q;
  assign sck_oe  = m_act_q;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = {master, 31'(HALF_PERIOD)};
  assign m_start    = 1'b0;
  assign m_rise     = 1'b0;
  assign m_fall     = 1'b0;
  assign m_act      = 1'b0;
  assign sck_out    = 1'b1;
  assign sck_oe     = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_eff;
    sout_d     = sout_q;
    low_d      = low_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_start || sck_fall) begin
          state_d = SHIFT;
          sout_d  = shreg_eff[BITS-1];
          low_d   = 1'b1;
        end
      end
      SHIFT: begin
        // low_q tracks which edge is due next; out-of-order edges are dropped.
        if (rise_ev && low_q) begin
          shreg_d   = {shreg_q[BITS-2:0], sin_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          low_d     = 1'b0;
          if (last_bit) begin
            rx_data_d  = {shreg_q[BITS-2:0], sin_s};
            rx_valid_d = 1'b1;
            shreg_d    = IDLE_BYTE;
            state_d    = IDLE;
          end
        end else if (fall_ev && !low_q) begin
          sout_d = shreg_q[BITS-1];
          low_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= IDLE_BYTE;
      sout_q     <= 1'b1;
      low_q      <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      sout_q     <= sout_d;
      low_q      <= low_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign sout     = sout_q;
  assign busy     = (state_q == SHIFT);
  assign tx_ready = (state_q == IDLE);
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
endmodule

// File: tb/tb_serial_link_peer.sv
// Directed bench: a timeline model of expected outputs, checked every cycle.
module tb_serial_link_peer;
  localparam int HP = 4;
  localparam int H  = 8;

  logic       clk = 1'b0, nreset = 1'b1, sck_in = 1'b1, sin = 1'b1;
  logic       master = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       sck_out, sck_oe, sout, tx_ready, rx_valid, busy;
  logic [7:0] rx_data;

  int cyc = 0, compared = 0, mismatched = 0, oe_cnt = 0, lo_cnt = 0;
  bit en = 1'b0;

  typedef struct {int at; int sig; logic [7:0] v;} ev_t;
  typedef struct {string nm; logic [31:0] a; logic [31:0] e;} lit_t;
  ev_t  evq[$];
  lit_t litq[$];

  logic       e_sout = 1'b1, e_busy = 1'b0, e_rxv = 1'b0, e_sck_out = 1'b1, e_oe = 1'b0;
  logic [7:0] e_rxd = 8'h00;
  logic [7:0] m_send = 8'hFF;

  serial_link_peer #(.HALF_PERIOD(HP)) dut (
    .clk      (clk),
    .nreset   (nreset),
    .sck_in   (sck_in),
    .sck_out  (sck_out),
    .sck_oe   (sck_oe),
    .sin      (sin),
    .sout     (sout),
    .master   (master),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  always @(negedge clk) begin
    lit_t l;
    if (!nreset) begin
      evq.delete();
      e_sout = 1'b1; e_busy = 1'b0; e_rxv = 1'b0; e_rxd = 8'h00;
      e_sck_out = 1'b1; e_oe = 1'b0;
    end
    for (int i = evq.size() - 1; i >= 0; i--) begin
      if (evq[i].at <= cyc) begin
        case (evq[i].sig)
          0: e_sout    = evq[i].v[0];
          1: e_busy    = evq[i].v[0];
          2: e_rxd     = evq[i].v;
          3: e_rxv     = evq[i].v[0];
          4: e_sck_out = evq[i].v[0];
          default: e_oe = evq[i].v[0];
        endcase
        evq.delete(i);
      end
    end
    if (en) begin
      chk("sout", sout, e_sout);
      chk("busy", busy, e_busy);
      chk("tx_ready", tx_ready, !e_busy);
      chk("rx_valid", rx_valid, e_rxv);
      chk("rx_data", rx_data, e_rxd);
      chk("sck_out", sck_out, e_sck_out);
      chk("sck_oe", sck_oe, e_oe);
      if (sck_oe) oe_cnt++;
      if (!sck_out) lo_cnt++;
    end
    while (litq.size() > 0) begin
      l = litq.pop_front();
      chk(l.nm, l.a, l.e);
    end
  end

  task automatic lit(string nm, logic [31:0] a, logic [31:0] e);
    litq.push_back('{nm, a, e});
  endtask

  task automatic push(int at, int sig, logic [7:0] v);
    evq.push_back('{at, sig, v});
  endtask

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    nreset = 1'b0;
    #1;
    lit("rst_sout", sout, 1);
    lit("rst_sck_oe", sck_oe, 0);
    lit("rst_sck_out", sck_out, 1);
    lit("rst_tx_ready", tx_ready, 1);
    lit("rst_busy", busy, 0);
    lit("rst_rx_valid", rx_valid, 0);
    lit("rst_rx_data", rx_data, 0);
    tick(2);
    nreset = 1'b1;
    tick(1);
  endtask

  task automatic load(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    m_send   = b;
    tick(1);
    tx_valid = 1'b0;
  endtask

  // DMG-side master: 8 SCK pulses of H low / H high, DMG bit changes on each fall.
  task automatic slave_xfer(input logic [7:0] dmg, input int nbits, input bit poke,
                            output logic [7:0] got);
    int c;
    got = 8'h00;
    for (int k = 0; k < nbits; k++) begin
      c = cyc;
      sck_in = 1'b0;
      sin    = dmg[7-k];
      push(c + 3, 0, {7'd0, m_send[7-k]});
      if (k == 0) push(c + 3, 1, 8'd1);
      tick(3);
      got[7-k] = sout;
      tick(H - 3);
      sck_in = 1'b1;
      c = cyc;
      if (k == 7) begin
        push(c + 3, 1, 8'd0);
        push(c + 3, 2, dmg);
        push(c + 3, 3, 8'd1);
        push(c + 4, 3, 8'd0);
        m_send = 8'hFF;
        tick(3);
        lit("rx_valid_pulse", rx_valid, 1);
        tick(1);
        lit("rx_valid_drop", rx_valid, 0);
        tick(H - 4);
      end else if (poke && k == 3) begin
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        tick(1);
        lit("tx_ready_busy", tx_ready, 0);
        tx_valid = 1'b0;
        tick(H - 1);
      end else begin
        tick(H);
      end
    end
  endtask

`ifdef SERIAL_LINK_PEER_MASTER_EN
  // Peer generates SCK: falls at start+1+2*HP*i, rises HP later, done after 15*HP.
  task automatic master_xfer(input logic [7:0] tx, input logic [7:0] dmg,
                             output logic [7:0] got);
    int n, fin;
    n = cyc;
    fin = n + 1 + 15 * HP;
    got = 8'h00;
    tx_data = tx; tx_valid = 1'b1; master = 1'b1;
    push(n + 1, 1, 8'd1);
    push(n + 1, 5, 8'd1);
    for (int i = 0; i < 8; i++) begin
      push(n + 1 + 2 * HP * i, 0, {7'd0, tx[7-i]});
      push(n + 1 + 2 * HP * i, 4, 8'd0);
      push(n + 1 + 2 * HP * i + HP, 4, 8'd1);
    end
    push(fin, 5, 8'd0);
    push(fin, 1, 8'd0);
    push(fin, 2, dmg);
    push(fin, 3, 8'd1);
    push(fin + 1, 3, 8'd0);
    m_send = 8'hFF;
    tick(1);
    tx_valid = 1'b0; master = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sin = dmg[7-i];
      got[7-i] = sout;
      tick(2 * HP);
    end
    sin = 1'b1;
  endtask
`endif

  initial begin
    logic [7:0] got;
    int oe0, lo0;
    do_reset();
    en = 1'b1;

    load(8'hA5);
    slave_xfer(8'h3C, 8, 1'b0, got);
    lit("slave_sout_seq", got, 8'hA5);
    lit("slave_rx", rx_data, 8'h3C);

    do_reset();
    slave_xfer(8'h81, 8, 1'b0, got);
    lit("noload_sout_seq", got, 8'hFF);
    lit("noload_rx", rx_data, 8'h81);

    load(8'h96);
    slave_xfer(8'h0F, 4, 1'b0, got);
    lit("abort_first_bits", got[7:4], 4'h9);
    lit("abort_busy", busy, 1);
    do_reset();
    load(8'hC3);
    slave_xfer(8'h6E, 8, 1'b0, got);
    lit("post_abort_sout_seq", got, 8'hC3);
    lit("post_abort_rx", rx_data, 8'h6E);

    slave_xfer(8'h24, 8, 1'b1, got);
    lit("poke_xfer_sout_seq", got, 8'hFF);
    slave_xfer(8'h42, 8, 1'b0, got);
    lit("ignored_byte_sout_seq", got, 8'hFF);
    load(8'h11);
    slave_xfer(8'h7E, 8, 1'b0, got);
    lit("represented_sout_seq", got, 8'h11);
    lit("represented_rx", rx_data, 8'h7E);

    oe0 = oe_cnt;
    lo0 = lo_cnt;
`ifdef SERIAL_LINK_PEER_MASTER_EN
    master_xfer(8'h5A, 8'hB4, got);
    lit("master_sout_seq", got, 8'h5A);
    lit("master_rx", rx_data, 8'hB4);
    lit("master_oe_cycles", oe_cnt - oe0, 60);
    lit("master_low_cycles", lo_cnt - lo0, 32);
`else
    master = 1'b1;
    load(8'h5A);
    master = 1'b0;
    tick(20);
    lit("no_master_busy", busy, 0);
    slave_xfer(8'hC0, 8, 1'b0, got);
    lit("no_master_sout_seq", got, 8'h5A);
    lit("no_master_rx", rx_data, 8'hC0);
    lit("no_master_oe_cycles", oe_cnt - oe0, 0);
    lit("no_master_low_cycles", lo_cnt - lo0, 0);
`endif

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
